uart_autobaud_ctrl: RTL

Configuration controller for the UART baud-rate tick generator. It drives the 16-bit divisor that sets the tick period, in clock cycles, at 16x the UART bit rate. The divisor comes from one of two sources: a software load, or automatic measurement of an incoming 0x55 sync character on Rx. The block sits beside the receiver, takes the raw Rx pin, and emits the BaudRate value plus an update strobe that restarts the tick generator.

---
 rtl/uart_autobaud_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl: chooses the divisor for the UART 16x tick generator.
// The divisor comes either from a software load or from timing the falling
// edges of an incoming 0x55 sync character on the raw Rx line.
//
// Pulse semantics: AutoBaudStart, Abort and SwLoad are single-cycle pulses
// acted on at the rising edge where they are high (no ready/acknowledge; a
// pulse arriving in a state that does not accept it is dropped).
// BaudUpdate is high for exactly the first cycle that BaudRate holds a new value.
module uart_autobaud_ctrl #(
    parameter int DEFAULT_DIV = 325,
    parameter int MIN_DIV     = 2,
    parameter int CNT_W       = 24
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Rx,
    input  logic        AutoBaudStart,
    input  logic        Abort,
    input  logic        SwLoad,
    input  logic [15:0] SwBaudRate,
    output logic [15:0] BaudRate,
    output logic        BaudUpdate,
    output logic        Busy,
    output logic        Locked,
    output logic        Error,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        MEASURE    = 2'd2,
        COMPUTE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   MEAS_ONE  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [15:0]      DEF_DIV16 = 16'(DEFAULT_DIV);
    localparam logic [15:0]      MIN_DIV16 = 16'(MIN_DIV);
    localparam logic [31:0]      MIN_DIV32 = MIN_DIV;
    localparam logic [31:0]      MAX_DIV32 = 32'd65535;

    // Rx synchroniser and edge-detect pipeline
    logic rx_meta;
    logic rx_s;
    logic rx_d;
    logic fall;

    // FSM state and measurement datapath
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       edges;
    logic [2:0]       edges_n;
    logic [CNT_W:0]   meas;
    logic [CNT_W:0]   meas_n;
    logic [31:0]      div_wide;

    // Next values of the registered outputs
    logic [15:0] baud_n;
    logic        update_n;
    logic        busy_n;
    logic        locked_n;
    logic        error_n;

    // Two-flop synchroniser on the asynchronous pin, plus one delay stage for edge detection
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

    // C/128 rounded to nearest; kept 32 bits wide so out-of-range results are visible
    assign div_wide = ({{(31-CNT_W){1'b0}}, meas} + 32'd64) >> 7;

    assign dbg_state = state;

    // State, measurement and output registers
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            edges      <= '0;
            meas       <= '0;
            BaudRate   <= DEF_DIV16;
            BaudUpdate <= 1'b0;
            Busy       <= 1'b0;
            Locked     <= 1'b0;
            Error      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            edges      <= edges_n;
            meas       <= meas_n;
            BaudRate   <= baud_n;
            BaudUpdate <= update_n;
            Busy       <= busy_n;
            Locked     <= locked_n;
            Error      <= error_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        edges_n  = edges;
        meas_n   = meas;
        baud_n   = BaudRate;
        update_n = 1'b0;
        locked_n = Locked;
        error_n  = Error;

        case (state)
            IDLE: begin
                // A start request takes priority over a simultaneous software load
                if (AutoBaudStart) begin
                    state_n  = WAIT_START;
                    error_n  = 1'b0;
                    locked_n = 1'b0;
                end else if (SwLoad) begin
                    if (SwBaudRate >= MIN_DIV16) begin
                        baud_n   = SwBaudRate;
                        update_n = 1'b1;
                        locked_n = 1'b0;
                        error_n  = 1'b0;
                    end else begin
                        error_n = 1'b1;
                    end
                end
            end

            WAIT_START: begin
                if (Abort) begin
                    state_n = IDLE;
                end else if (fall) begin
                    state_n = MEASURE;
                    cnt_n   = '0;
                    edges_n = 3'd1;
                end
            end

            MEASURE: begin
                // The fifth fall closes the 8-bit-time window from start bit to d7
                if (Abort) begin
                    state_n = IDLE;
                end else if (fall && (edges == 3'd4)) begin
                    edges_n = 3'd5;
                    meas_n  = {1'b0, cnt} + MEAS_ONE;
                    state_n = COMPUTE;
                end else if (cnt == CNT_MAX) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                    if (fall) begin
                        edges_n = edges + 3'd1;
                    end
                end
            end

            COMPUTE: begin
                if ((div_wide < MIN_DIV32) || (div_wide > MAX_DIV32)) begin
                    error_n = 1'b1;
                end else begin
                    baud_n   = div_wide[15:0];
                    update_n = 1'b1;
                    locked_n = 1'b1;
                end
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule
